// File: rtl/gaussian_outbuf.sv
// gaussian_outbuf: frame store for filtered pixels. Pixels are written by
// address while idle; a rising edge on writefile streams the whole frame out
// in raster order over a valid/ready link, with the filter halo replaced by
// BORDER_VAL.
module gaussian_outbuf #(
  parameter int BITS       = 8,
  parameter int ADDRLEN    = 21,
  parameter int ROW        = 720,
  parameter int COL        = 1280,
  parameter int HALO       = 3,
  parameter int BORDER_VAL = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDRLEN-1:0] inpixeladdr,
  input  logic [BITS-1:0]    input_pixel,
  input  logic               wenbuffer,
  input  logic               writefile,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [BITS-1:0]    out_data,
  output logic               out_sof,
  output logic               out_eol,
  output logic               done,
  output logic               busy,
  output logic               err
);

  localparam int NPIX_I = ROW * COL;
  localparam int AW     = (NPIX_I > 1) ? $clog2(NPIX_I) : 1;
  localparam int RW     = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int CW     = (COL > 1) ? $clog2(COL) : 1;
  // Frame size held in one bit more than the address so the bound compare is exact.
  localparam logic [ADDRLEN:0] NPIX   = (ADDRLEN + 1)'(NPIX_I);
  localparam logic [BITS-1:0]  BVAL   = BITS'(BORDER_VAL);
  localparam logic [RW-1:0]    LAST_R = RW'(ROW - 1);
  localparam logic [CW-1:0]    LAST_C = CW'(COL - 1);

  typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

  state_t state, state_nxt;

  logic [BITS-1:0] mem [NPIX_I];

  logic          wf_q, wf_rise;
  logic          wr_ok, wr_bad;
  logic [AW-1:0] icnt;
  logic [RW-1:0] ir;
  logic [CW-1:0] ic;
  logic          issued_all;
  logic          adv_p0, adv_p1, issue, rd_en, xfer;

  logic          vld_p0, bord_p0, sof_p0, eol_p0, last_p0;
  logic [AW-1:0] addr_p0;
  logic          vld_p1, bord_p1, sof_p1, eol_p1, last_p1;
  logic [BITS-1:0] data_p1;

  // Pixels inside the halo ring are not produced by the filter.
  function automatic logic is_border(input logic [RW-1:0] r, input logic [CW-1:0] c);
    int ri;
    int ci;
    ri = int'(r);
    ci = int'(c);
    return (ri < HALO) || (ri >= ROW - HALO) || (ci < HALO) || (ci >= COL - HALO);
  endfunction

  assign wf_rise = writefile && !wf_q;
  assign wr_ok   = wenbuffer && (state == IDLE) && ({1'b0, inpixeladdr} < NPIX);
  assign wr_bad  = wenbuffer && !wr_ok;

  // Pipeline advances: the output stage empties on a transfer, the address
  // stage moves whenever the stage ahead of it can take its contents.
  assign adv_p1 = !vld_p1 || out_ready;
  assign adv_p0 = !vld_p0 || adv_p1;
  assign issue  = (state == DUMP) && adv_p0 && !issued_all;
  assign rd_en  = (state == DUMP) && adv_p1 && vld_p0;
  assign xfer   = vld_p1 && out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wf_rise) state_nxt = DUMP;
      DUMP:    if (xfer && last_p1) state_nxt = DONE;
      DONE:    if (!writefile) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: edge detect (starts high so a level held through reset is not
  // seen as a new request), sticky error, valids and raster counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wf_q       <= 1'b1;
      err        <= 1'b0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      icnt       <= '0;
      ir         <= '0;
      ic         <= '0;
      issued_all <= 1'b0;
    end else begin
      wf_q <= writefile;
      if (wr_bad) err <= 1'b1;
      if (state == DUMP) begin
        if (adv_p1) vld_p1 <= vld_p0;
        if (adv_p0) vld_p0 <= !issued_all;
        if (issue) begin
          icnt <= icnt + AW'(1);
          if (ic == LAST_C) begin
            ic <= '0;
            if (ir == LAST_R) issued_all <= 1'b1;
            else              ir <= ir + RW'(1);
          end else begin
            ic <= ic + CW'(1);
          end
        end
      end else begin
        vld_p0     <= 1'b0;
        vld_p1     <= 1'b0;
        icnt       <= '0;
        ir         <= '0;
        ic         <= '0;
        issued_all <= 1'b0;
      end
    end
  end

  // Datapath: storage write, p0 address/tag stage, p1 gated registered read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[inpixeladdr[AW-1:0]] <= input_pixel;
    // ---- p0: read address and beat tags ----
    if (issue) begin
      addr_p0 <= icnt;
      bord_p0 <= is_border(ir, ic);
      sof_p0  <= (icnt == '0);
      eol_p0  <= (ic == LAST_C);
      last_p0 <= (ir == LAST_R) && (ic == LAST_C);
    end
    // ---- p1: registered read, held while the beat is stalled ----
    if (rd_en) begin
      data_p1 <= mem[addr_p0];
      bord_p1 <= bord_p0;
      sof_p1  <= sof_p0;
      eol_p1  <= eol_p0;
      last_p1 <= last_p0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = vld_p1 ? (bord_p1 ? BVAL : data_p1) : '0;
  assign out_sof   = vld_p1 && sof_p1;
  assign out_eol   = vld_p1 && eol_p1;
  assign busy      = (state == DUMP);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_gaussian_outbuf.sv
// tb_gaussian_outbuf: table-driven write/error vectors plus full-frame dumps
// checked against a frame-array reference model with halo masking.
module tb_gaussian_outbuf;

  localparam int BITS    = 8;
  localparam int ADDRLEN = 8;
  localparam int ROW     = 8;
  localparam int COL     = 10;
  localparam int HALO    = 3;
  localparam int BV      = 0;
  localparam int NPIX    = ROW * COL;

  logic               clk = 1'b0;
  logic               rst;
  logic [ADDRLEN-1:0] inpixeladdr;
  logic [BITS-1:0]    input_pixel;
  logic               wenbuffer;
  logic               writefile;
  logic               out_ready;
  logic               out_valid;
  logic [BITS-1:0]    out_data;
  logic               out_sof;
  logic               out_eol;
  logic               done;
  logic               busy;
  logic               err;

  always #5 clk = ~clk;

  gaussian_outbuf #(
    .BITS(BITS), .ADDRLEN(ADDRLEN), .ROW(ROW), .COL(COL), .HALO(HALO), .BORDER_VAL(BV)
  ) dut (
    .clk(clk), .rst(rst), .inpixeladdr(inpixeladdr), .input_pixel(input_pixel),
    .wenbuffer(wenbuffer), .writefile(writefile), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
    .done(done), .busy(busy), .err(err)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [BITS-1:0] ref_mem [NPIX];
  logic ref_err;

  typedef struct {
    logic               wen;
    logic [ADDRLEN-1:0] addr;
    logic [BITS-1:0]    pix;
    logic               exp_err;
  } wvec_t;
  wvec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: stored pixel unless inside the halo ring.
  function automatic logic [BITS-1:0] exp_pix(input int k);
    int r;
    int c;
    r = k / COL;
    c = k % COL;
    if (r < HALO || r >= ROW - HALO || c < HALO || c >= COL - HALO) return BITS'(BV);
    return ref_mem[k];
  endfunction

  // Single write while idle; model stores in-range writes, flags the rest.
  task automatic wr(input int a, input logic [BITS-1:0] v);
    wenbuffer   = 1'b1;
    inpixeladdr = ADDRLEN'(a);
    input_pixel = v;
    step();
    wenbuffer = 1'b0;
    if (a < NPIX) ref_mem[a] = v;
    else          ref_err = 1'b1;
  endtask

  // mode 0: ready always 1; 1: ready pattern 1,0,0,1; 2: random ready.
  task automatic run_dump(input int mode, input bit wr_start, input bit wr_mid, input int abort_at);
    int k;
    int cyc;
    int first_v;
    bit stalled;
    bit rdy;
    bit aborted;
    logic [BITS-1:0] h_data;
    logic h_sof;
    logic h_eol;
    k = 0; cyc = 0; first_v = -1; stalled = 0; aborted = 0;
    h_data = '0; h_sof = 0; h_eol = 0;
    writefile = 1'b1;
    if (wr_start) begin
      wenbuffer = 1'b1; inpixeladdr = 8'd33; input_pixel = 8'hAB;
    end
    step();
    wenbuffer = 1'b0;
    check("busy_start", busy, 1);
    while (k < NPIX && cyc < 400) begin
      if (abort_at >= 0 && k == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_data", out_data, 0);
        check("abort_sof", out_sof, 0);
        check("abort_eol", out_eol, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        ref_err = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
          step();
          check("held_no_dump_busy", busy, 0);
          check("held_no_dump_valid", out_valid, 0);
        end
        aborted = 1;
        break;
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, h_data);
        check("stall_sof", out_sof, h_sof);
        check("stall_eol", out_eol, h_eol);
      end
      if (wr_mid && cyc == 3) begin
        wenbuffer = 1'b1; inpixeladdr = 8'd44; input_pixel = 8'hEE; ref_err = 1'b1;
      end else begin
        wenbuffer = 1'b0;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      out_ready = rdy;
      stalled = 0;
      if (out_valid) begin
        if (rdy) begin
          check($sformatf("beat%0d_data", k), out_data, exp_pix(k));
          check($sformatf("beat%0d_sof", k), out_sof, (k == 0));
          check($sformatf("beat%0d_eol", k), out_eol, (k % COL == COL - 1));
          k++;
        end else begin
          stalled = 1; h_data = out_data; h_sof = out_sof; h_eol = out_eol;
        end
      end
      step();
      cyc++;
    end
    wenbuffer = 1'b0;
    out_ready = 1'b1;
    if (!aborted) begin
      check("beat_count", k, NPIX);
      check("first_valid_latency", first_v, 2);
      if (mode == 0) check("no_bubbles", cyc, 2 + NPIX);
      check("end_valid", out_valid, 0);
      check("end_done", done, 1);
      check("end_busy", busy, 0);
      check("end_err", err, ref_err);
    end
  endtask

  task automatic drop_wf();
    writefile = 1'b0;
    step();
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; wenbuffer = 1'b0; writefile = 1'b0; out_ready = 1'b0;
    inpixeladdr = '0; input_pixel = '0; ref_err = 1'b0;
    tbl[0] = '{1'b1, 8'd5,   8'h11, 1'b0};
    tbl[1] = '{1'b1, 8'd79,  8'h22, 1'b0};
    tbl[2] = '{1'b0, 8'd80,  8'h33, 1'b0};
    tbl[3] = '{1'b0, 8'd35,  8'h34, 1'b0};
    tbl[4] = '{1'b1, 8'd80,  8'h44, 1'b1};
    tbl[5] = '{1'b1, 8'd172, 8'h66, 1'b1};
    tbl[6] = '{1'b1, 8'd43,  8'h77, 1'b1};

    repeat (3) step();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sof", out_sof, 0);
    check("rst_eol", out_eol, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    step();

    // Frame of r*COL+c, which with COL=10 is r*10+c.
    for (int a = 0; a < NPIX; a++) wr(a, BITS'(a));

    // Table of writes and the sticky error they must leave behind.
    for (int i = 0; i < 7; i++) begin
      wenbuffer = tbl[i].wen; inpixeladdr = tbl[i].addr; input_pixel = tbl[i].pix;
      step();
      wenbuffer = 1'b0;
      if (tbl[i].wen && tbl[i].addr < NPIX) ref_mem[tbl[i].addr] = tbl[i].pix;
      check($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
    end

    // Reset clears the error but not the stored frame.
    rst = 1'b1; step(); rst = 1'b0; ref_err = 1'b0; step();
    check("err_cleared", err, 0);

    // Continuous dump, then writefile held high must not restart it.
    run_dump(0, 0, 0, -1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_done", done, 1);
      check("hold_valid", out_valid, 0);
      check("hold_busy", busy, 0);
    end
    drop_wf();

    // Backpressure pattern.
    run_dump(1, 0, 0, -1);
    drop_wf();

    // Out-of-range write and a write during the dump.
    wr(80, 8'h99);
    check("oor_err", err, 1);
    run_dump(0, 0, 1, -1);
    drop_wf();

    // Write committed on the same edge as the dump request.
    ref_mem[33] = 8'hAB;
    run_dump(0, 1, 0, -1);
    drop_wf();

    // Reset mid-dump, then a fresh request dumps the whole frame.
    run_dump(0, 0, 0, 20);
    drop_wf();
    run_dump(0, 0, 0, -1);
    drop_wf();

    // Writes accepted again after returning to idle; random frame and ready.
    wr(44, 8'h5A);
    check("post_done_write_err", err, 0);
    for (int a = 0; a < NPIX; a++) wr(a, BITS'($urandom));
    run_dump(2, 0, 0, -1);
    drop_wf();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gaussian_outbuf.md
GAUSSIAN_OUTBUF -- requirements
Module: gaussian_outbuf

Interface
REQ-001 SHALL have parameter BITS, default 8, pixel width.
REQ-002 SHALL have parameter ADDRLEN, default 21, pixel address width.
REQ-003 SHALL have parameter ROW, default 720, frame rows; COL, default 1280, frame columns.
REQ-004 SHALL have parameter HALO, default 3, border width not produced by the filter; BORDER_VAL, default 0, value emitted for border pixels.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port inpixeladdr  input  ADDRLEN  linear write address (row*COL+col).
REQ-008 SHALL have port input_pixel  input  BITS  filtered pixel to store.
REQ-009 SHALL have port wenbuffer  input  1  write strobe for inpixeladdr/input_pixel.
REQ-010 SHALL have port writefile  input  1  level; frame complete, request dump.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-012 SHALL have ports out_valid  output  1; out_data  output  BITS; out_sof  output  1 (first pixel); out_eol  output  1 (last pixel of row).
REQ-013 SHALL have ports done  output  1  dump finished; busy  output  1  dump in progress; err  output  1  sticky write error.

Function
REQ-014 SHALL contain ROW*COL x BITS storage, synchronous write, one-cycle registered read.
REQ-015 States: IDLE, DUMP, DONE; reset state IDLE.
REQ-016 IDLE: wenbuffer=1 and inpixeladdr<ROW*COL -> store input_pixel at inpixeladdr on that edge.
REQ-017 IDLE: wenbuffer=1 and inpixeladdr>=ROW*COL -> no store, err set.
REQ-018 DUMP/DONE: wenbuffer=1 -> no store, err set.
REQ-019 IDLE -> DUMP on a cycle where writefile=1 and writefile was 0 the previous cycle (rising edge); a write in that same cycle SHALL be committed first.
REQ-020 Dump order: raster, row 0..ROW-1, col 0..COL-1, exactly ROW*COL beats.
REQ-021 Pixel (r,c) with r<HALO, r>=ROW-HALO, c<HALO or c>=COL-HALO SHALL emit BORDER_VAL regardless of stored content; all others emit stored value.
REQ-022 First out_valid SHALL assert 2 cycles after the edge entering DUMP (1 read-address cycle + 1 read-latency cycle).
REQ-023 Handshake: beat transfers when out_valid & out_ready; while out_valid & !out_ready, out_data/out_sof/out_eol SHALL hold stable and out_valid SHALL stay 1.
REQ-024 With out_ready held 1, throughput SHALL be one beat per cycle with no bubbles (read pipeline stalled via skid register or read-enable gating).
REQ-025 out_sof=1 only with beat (0,0); out_eol=1 with every beat where c=COL-1.
REQ-026 After transfer of beat (ROW-1,COL-1): out_valid=0 next cycle, state -> DONE.
REQ-027 DONE: done=1; returns to IDLE when writefile=0; err unchanged; storage retained.
REQ-028 busy=1 exactly while in DUMP; done=1 exactly while in DONE.
REQ-029 Address compare SHALL use ADDRLEN bits; ROW*COL SHALL be computed as a constant no wider than ADDRLEN+1 bits.

Reset
REQ-030 rst=1 SHALL immediately force: state IDLE, out_valid=0, out_data=0, out_sof=0, out_eol=0, busy=0, done=0, err=0, dump counters 0.
REQ-031 Storage contents SHALL NOT be cleared by reset.
REQ-032 rst asserted mid-dump SHALL abort the dump; after release, a new writefile rising edge SHALL be required to dump.

Verification (ROW=8, COL=10, HALO=3, BORDER_VAL=0)
REQ-033 Write pixel value (r*10+c) at all 80 addresses, pulse writefile, out_ready=1 -> 80 consecutive beats, out_valid 2 cycles after start, interior (3..4,3..6) = r*10+c, all others 0, out_sof on beat 0, out_eol on beats 9,19,...,79, done=1 after.
REQ-034 Same frame, out_ready toggling 1,0,0,1 pattern -> identical beat sequence, data stable across all stall cycles, no beat lost or duplicated.
REQ-035 Write to address 80, and a write during DUMP -> err=1 and stays 1, neither write alters dump data.
REQ-036 wenbuffer=1 to address 33 with value 0xAB on same cycle as writefile rising -> dumped beat 33 = 0xAB.
REQ-037 rst pulsed after 20 beats -> all outputs at reset values asynchronously; writefile held high yields no dump; writefile low then high -> full 80-beat dump from (0,0).
REQ-038 writefile held high after DONE -> no second dump; drop writefile -> IDLE, writes accepted again.
